// File: rtl/clock_divider_pkg.sv
// Shared helpers for the clock divider bank: index width and the stopped-divider value.
package clock_divider_pkg;

    localparam int unsigned DIV_STOP = 0;

    function automatic int unsigned ch_idx_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/clock_divider_channel.sv
// One divider channel: counter, phase boundary, shadow/active ratio and optional tick.
// Tick flops exist only when CLOCK_DIVIDER_BANK_TICK_EN is defined.
module clock_divider_channel import clock_divider_pkg::*; #(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned DEFAULT_DIV = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sync,
    input  logic             wr_en,
    input  logic [CNT_W-1:0] wr_div,
    output logic             pending,
    output logic             clk_out,
    output logic             tick
);

    typedef struct packed {
        logic [CNT_W-1:0] counter;
        logic [CNT_W-1:0] active_div;
        logic [CNT_W-1:0] shadow_div;
        logic             out;
    } ch_state_t;

    localparam logic [CNT_W-1:0] STOP_VAL  = CNT_W'(DIV_STOP);
    localparam logic [CNT_W-1:0] RESET_DIV = CNT_W'(DEFAULT_DIV);

    ch_state_t        state_q, state_d;
    logic             pending_q, pending_d;
    logic [CNT_W-1:0] shadow_next;
    logic             stopped;
    logic             boundary;

    always_comb begin
        shadow_next = wr_en ? wr_div : state_q.shadow_div;
        stopped     = (state_q.active_div == STOP_VAL);
        // A stopped channel has no phase to finish, so every cycle acts as a boundary.
        boundary    = stopped || (state_q.counter == state_q.active_div - CNT_W'(1));

        state_d            = state_q;
        state_d.shadow_div = shadow_next;
        pending_d          = pending_q | wr_en;

        if (en) begin
            if (sync) begin
                state_d.counter    = '0;
                state_d.out        = 1'b0;
                state_d.active_div = shadow_next;
                pending_d          = 1'b0;
            end else if (boundary) begin
                state_d.counter    = '0;
                state_d.active_div = shadow_next;
                state_d.out        = (stopped || (shadow_next == STOP_VAL)) ? 1'b0 : ~state_q.out;
                pending_d          = 1'b0;
            end else begin
                state_d.counter = state_q.counter + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q.counter    <= '0;
            state_q.active_div <= RESET_DIV;
            state_q.shadow_div <= RESET_DIV;
            state_q.out        <= 1'b0;
            pending_q          <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
        end
    end

    assign pending = pending_q;
    assign clk_out = state_q.out;

`ifdef CLOCK_DIVIDER_BANK_TICK_EN
    logic tick_q;

    // Output only rises through a normal boundary toggle; sync and stop force it low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= state_d.out & ~state_q.out;
        end
    end

    assign tick = tick_q;
`else
    assign tick = 1'b0;
`endif

endmodule

// File: rtl/clock_divider_bank.sv
// Bank of run-time programmable square-wave dividers; top decodes the config index.
// Optional tick output enabled by CLOCK_DIVIDER_BANK_TICK_EN.
module clock_divider_bank import clock_divider_pkg::*; #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned DEFAULT_DIV = 5
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_CH-1:0]                 en,
    input  logic                              sync,
    input  logic                              cfg_we,
    input  logic [ch_idx_w(NUM_CH)-1:0]       cfg_ch,
    input  logic [CNT_W-1:0]                  cfg_div,
    output logic [NUM_CH-1:0]                 pending,
    output logic [NUM_CH-1:0]                 clk_out,
    output logic [NUM_CH-1:0]                 tick
);

    localparam int unsigned CH_IDX_W = ch_idx_w(NUM_CH);

    logic [NUM_CH-1:0] wr_en;

    // Indices at or above NUM_CH match no channel and are dropped.
    always_comb begin
        wr_en = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            wr_en[i] = cfg_we && (cfg_ch == CH_IDX_W'(i));
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clock_divider_channel #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (en[g]),
            .sync    (sync),
            .wr_en   (wr_en[g]),
            .wr_div  (cfg_div),
            .pending (pending[g]),
            .clk_out (clk_out[g]),
            .tick    (tick[g])
        );
    end

endmodule

// File: tb/tb_clock_divider_bank.sv
// Randomised bench for clock_divider_bank against a cycle-level phase model.
module tb_clock_divider_bank;

    localparam int unsigned NUM_CH      = 4;
    localparam int unsigned CNT_W       = 32;
    localparam int unsigned DEFAULT_DIV = 5;

`ifdef CLOCK_DIVIDER_BANK_TICK_EN
    localparam bit TICK_ON = 1'b1;
`else
    localparam bit TICK_ON = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    logic [NUM_CH-1:0] en;
    logic              sync;
    logic              cfg_we;
    logic [1:0]        cfg_ch;
    logic [CNT_W-1:0]  cfg_div;
    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick;

    clock_divider_bank #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .sync    (sync),
        .cfg_we  (cfg_we),
        .cfg_ch  (cfg_ch),
        .cfg_div (cfg_div),
        .pending (pending),
        .clk_out (clk_out),
        .tick    (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_tests;
    int unsigned n_failed;
    int unsigned cyc;

    // Model: half-period length, cycles spent in current phase, level, queued ratio.
    int unsigned m_half [NUM_CH];
    int unsigned m_spent[NUM_CH];
    int unsigned m_queue[NUM_CH];
    bit          m_level[NUM_CH];
    bit          m_pend [NUM_CH];
    bit          m_rose [NUM_CH];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_failed++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_half[c]  = DEFAULT_DIV;
            m_spent[c] = 0;
            m_queue[c] = DEFAULT_DIV;
            m_level[c] = 1'b0;
            m_pend[c]  = 1'b0;
            m_rose[c]  = 1'b0;
        end
    endtask

    task automatic model_step();
        for (int c = 0; c < NUM_CH; c++) begin
            bit          wr;
            bit          prev;
            int unsigned req;
            wr   = cfg_we && (int'(cfg_ch) == c);
            req  = wr ? int'(cfg_div) : m_queue[c];
            prev = m_level[c];
            m_queue[c] = req;
            if (!en[c]) begin
                if (wr) m_pend[c] = 1'b1;
            end else if (sync) begin
                m_spent[c] = 0;
                m_level[c] = 1'b0;
                m_half[c]  = req;
                m_pend[c]  = 1'b0;
            end else if (m_half[c] == 0) begin
                m_level[c] = 1'b0;
                m_half[c]  = req;
                m_pend[c]  = 1'b0;
            end else begin
                m_spent[c] = m_spent[c] + 1;
                if (m_spent[c] == m_half[c]) begin
                    m_spent[c] = 0;
                    m_half[c]  = req;
                    m_level[c] = (req == 0) ? 1'b0 : !m_level[c];
                    m_pend[c]  = 1'b0;
                end else if (wr) begin
                    m_pend[c] = 1'b1;
                end
            end
            m_rose[c] = TICK_ON && m_level[c] && !prev;
        end
    endtask

    task automatic compare_all(input string tag);
        logic [NUM_CH-1:0] e_out, e_pend, e_tick;
        for (int c = 0; c < NUM_CH; c++) begin
            e_out[c]  = m_level[c];
            e_pend[c] = m_pend[c];
            e_tick[c] = m_rose[c];
        end
        check_eq({tag, ".clk_out"}, 32'(clk_out), 32'(e_out));
        check_eq({tag, ".pending"}, 32'(pending), 32'(e_pend));
        check_eq({tag, ".tick"}, 32'(tick), 32'(e_tick));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step();
        cyc++;
        #1;
        compare_all(tag);
    endtask

    initial begin
        int unsigned rst_hold;
        n_tests  = 0;
        n_failed = 0;
        cyc      = 0;
        rst_n    = 1'b0;
        en       = '1;
        sync     = 1'b0;
        cfg_we   = 1'b0;
        cfg_ch   = '0;
        cfg_div  = '0;
        model_reset();
        #12;
        check_eq("reset.clk_out", 32'(clk_out), 32'h0);
        check_eq("reset.pending", 32'(pending), 32'h0);
        check_eq("reset.tick", 32'(tick), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed: default ratio, then a mid-phase write of 3 to channel 1.
        for (int i = 0; i < 30; i++) begin
            step("dir");
            if (cyc == 5) begin
                check_eq("rise5", 32'(clk_out), 32'hF);
                check_eq("tick5", 32'(tick), TICK_ON ? 32'hF : 32'h0);
            end
            if (cyc == 8)  check_eq("pend8", 32'(pending), 32'h2);
            if (cyc == 10) check_eq("fall10", 32'(clk_out), 32'h0);
            if (cyc == 10) check_eq("pend10", 32'(pending), 32'h0);
            if (cyc == 13) check_eq("ch1_rise13", 32'(clk_out), 32'h2);
            if (cyc == 16) check_eq("ch1_fall16", 32'(clk_out), 32'hD);
            cfg_we  = (cyc == 7);
            cfg_ch  = 2'd1;
            cfg_div = 32'd3;
        end

        // Randomised traffic including stops, disables, sync and async resets.
        rst_hold = 0;
        for (int i = 0; i < 4000; i++) begin
            if (rst_hold != 0) begin
                rst_hold--;
                if (rst_hold == 0) rst_n = 1'b1;
            end else if ($urandom_range(0, 600) == 0) begin
                rst_n = 1'b0;
                #1;
                model_reset();
                compare_all("async_rst");
                rst_hold = 2;
            end
            if ($urandom_range(0, 7) == 0) begin
                en = 4'($urandom_range(0, 15));
            end else if ($urandom_range(0, 3) == 0) begin
                en = '1;
            end
            sync    = ($urandom_range(0, 40) == 0);
            cfg_we  = !sync && ($urandom_range(0, 5) == 0);
            cfg_ch  = 2'($urandom_range(0, 3));
            cfg_div = 32'($urandom_range(0, 6));
            step("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule
